// File: rtl/decode_stage_if.sv
// Handshake and decoded-bundle bus between IF, the ID stage and EX.
// The master side is the IF/EX environment; the slave side is decode_stage.
interface decode_stage_if #(
  parameter int RF_ADDR_W   = 4,
  parameter int IMM_W       = 8,
  parameter int OFF_W       = 9,
  parameter int STALL_CNT_W = 16
);
  logic                   if_valid;
  logic [15:0]            if_instr;
  logic                   id_ready;
  logic                   flush;
  logic                   ex_ready;
  logic                   id_valid;
  logic [3:0]             id_opcode;
  logic [RF_ADDR_W-1:0]   id_rd;
  logic [RF_ADDR_W-1:0]   id_rs;
  logic [RF_ADDR_W-1:0]   id_rt;
  logic                   id_rs_used;
  logic                   id_rt_used;
  logic [IMM_W-1:0]       id_imm;
  logic [OFF_W-1:0]       id_off;
  logic [2:0]             id_cond;
  logic                   id_mem_we;
  logic                   id_mem_re;
  logic                   id_reg_we;
  logic                   halted;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output if_valid, if_instr, flush, ex_ready,
    input  id_ready, id_valid, id_opcode, id_rd, id_rs, id_rt, id_rs_used, id_rt_used,
           id_imm, id_off, id_cond, id_mem_we, id_mem_re, id_reg_we, halted, stall_cnt
  );

  modport slave (
    input  if_valid, if_instr, flush, ex_ready,
    output id_ready, id_valid, id_opcode, id_rd, id_rs, id_rt, id_rs_used, id_rt_used,
           id_imm, id_off, id_cond, id_mem_we, id_mem_re, id_reg_we, halted, stall_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// Registered ID stage for the 16-bit WISC core: decodes accepted words, holds the
// bundle for EX, inserts one bubble on a load-use hazard and halts sticky on HLT.
module decode_stage #(
  parameter int RF_ADDR_W      = 4,
  parameter int IMM_W          = 8,
  parameter int OFF_W          = 9,
  parameter int LOAD_USE_STALL = 1,
  parameter int STALL_CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave bus
);

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LLB = 4'hA;
  localparam logic [3:0] OP_LHB = 4'hB;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic {
    S_RUN,
    S_HALTED
  } state_t;

  typedef struct packed {
    logic [3:0]           opcode;
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_ADDR_W-1:0] rs;
    logic [RF_ADDR_W-1:0] rt;
    logic                 rs_used;
    logic                 rt_used;
    logic [IMM_W-1:0]     imm;
    logic [OFF_W-1:0]     off;
    logic [2:0]           cond;
    logic                 mem_we;
    logic                 mem_re;
    logic                 reg_we;
  } bundle_t;

  // Register fields come from the low RF_ADDR_W bits of each nibble slot.
  function automatic bundle_t decode(input logic [15:0] instr);
    bundle_t d;
    logic [3:0] op;
    d        = '0;
    op       = instr[15:12];
    d.opcode = op;
    d.rd     = instr[8 +: RF_ADDR_W];
    d.imm    = instr[IMM_W-1:0];
    d.cond   = instr[11:9];
    if (op <= 4'h7) begin
      d.rs      = instr[4 +: RF_ADDR_W];
      d.rt      = instr[0 +: RF_ADDR_W];
      d.rs_used = 1'b1;
      d.rt_used = 1'b1;
    end else begin
      case (op)
        OP_LW: begin
          d.rs      = instr[8 +: RF_ADDR_W];
          d.rt      = instr[4 +: RF_ADDR_W];
          d.rt_used = 1'b1;
        end
        OP_SW: begin
          d.rs      = instr[8 +: RF_ADDR_W];
          d.rt      = instr[4 +: RF_ADDR_W];
          d.rs_used = 1'b1;
          d.rt_used = 1'b1;
        end
        OP_LLB, OP_LHB: begin
          d.rs      = instr[8 +: RF_ADDR_W];
          d.rs_used = 1'b1;
        end
        OP_BR: begin
          d.rs      = instr[4 +: RF_ADDR_W];
          d.rs_used = 1'b1;
        end
        OP_B:    d.off = instr[OFF_W-1:0];
        default: ;
      endcase
    end
    d.mem_we = (op == OP_SW);
    d.mem_re = (op == OP_LW);
    d.reg_we = (((op <= OP_LHB) && (op != OP_SW)) || (op == OP_PCS)) && (d.rd != '0);
    return d;
  endfunction

  state_t                 state_q, state_d;
  logic                   rdy_en_q;
  logic                   vld_q, vld_d;
  bundle_t                bndl_q, bndl_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  bundle_t dec;
  logic    advance;
  logic    hazard;
  logic    id_ready;
  logic    accept;

  assign dec     = decode(bus.if_instr);
  assign advance = !vld_q || bus.ex_ready;

  // A held LW whose destination is read by the incoming word must leave before it is taken.
  assign hazard = (LOAD_USE_STALL != 0) && vld_q && bndl_q.mem_re && bndl_q.reg_we &&
                  bus.if_valid &&
                  ((dec.rs_used && (dec.rs == bndl_q.rd)) ||
                   (dec.rt_used && (dec.rt == bndl_q.rd)));

  // rdy_en_q keeps id_ready low through reset and until the first edge after release.
  assign id_ready = rdy_en_q && advance && !hazard && (state_q == S_RUN) && !bus.flush;
  assign accept   = bus.if_valid && id_ready;

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    bndl_d  = bndl_q;
    cnt_d   = cnt_q;

    if (bus.flush) begin
      vld_d = 1'b0;
    end else if (accept) begin
      vld_d = 1'b1;
    end else if (advance) begin
      vld_d = 1'b0;
    end

    if (accept) begin
      bndl_d = dec;
    end

    if (hazard && advance && (cnt_q != '1)) begin
      cnt_d = cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end

    case (state_q)
      S_RUN:    if (accept && (dec.opcode == OP_HLT)) state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      rdy_en_q <= 1'b0;
      vld_q    <= 1'b0;
      bndl_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      vld_q    <= vld_d;
      bndl_q   <= bndl_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.id_ready   = id_ready;
  assign bus.id_valid   = vld_q;
  assign bus.id_opcode  = bndl_q.opcode;
  assign bus.id_rd      = bndl_q.rd;
  assign bus.id_rs      = bndl_q.rs;
  assign bus.id_rt      = bndl_q.rt;
  assign bus.id_rs_used = bndl_q.rs_used;
  assign bus.id_rt_used = bndl_q.rt_used;
  assign bus.id_imm     = bndl_q.imm;
  assign bus.id_off     = bndl_q.off;
  assign bus.id_cond    = bndl_q.cond;
  assign bus.id_mem_we  = bndl_q.mem_we;
  assign bus.id_mem_re  = bndl_q.mem_re;
  assign bus.id_reg_we  = bndl_q.reg_we;
  assign bus.halted     = (state_q == S_HALTED);
  assign bus.stall_cnt  = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (load-use stall on/off) share one stimulus
// stream; a behavioural model checks them every cycle, plus directed literal checks.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        drv_valid = 1'b0;
  logic [15:0] drv_instr = 16'h0;
  logic        drv_er = 1'b0;
  logic        drv_fl = 1'b0;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_stage_if bus0 ();
  decode_stage_if bus1 ();

  assign bus0.if_valid = drv_valid;
  assign bus0.if_instr = drv_instr;
  assign bus0.ex_ready = drv_er;
  assign bus0.flush    = drv_fl;
  assign bus1.if_valid = drv_valid;
  assign bus1.if_instr = drv_instr;
  assign bus1.ex_ready = drv_er;
  assign bus1.flush    = drv_fl;

  decode_stage #(.LOAD_USE_STALL(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  decode_stage #(.LOAD_USE_STALL(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct packed {
    logic        id_ready;
    logic        id_valid;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic        rs_used;
    logic        rt_used;
    logic [7:0]  imm;
    logic [8:0]  off;
    logic [2:0]  cond;
    logic        mem_we;
    logic        mem_re;
    logic        reg_we;
    logic        halted;
    logic [15:0] cnt;
  } outs_t;

  outs_t dut_o [2];

  assign dut_o[0] = '{bus0.id_ready, bus0.id_valid, bus0.id_opcode, bus0.id_rd, bus0.id_rs,
                      bus0.id_rt, bus0.id_rs_used, bus0.id_rt_used, bus0.id_imm, bus0.id_off,
                      bus0.id_cond, bus0.id_mem_we, bus0.id_mem_re, bus0.id_reg_we,
                      bus0.halted, bus0.stall_cnt};
  assign dut_o[1] = '{bus1.id_ready, bus1.id_valid, bus1.id_opcode, bus1.id_rd, bus1.id_rs,
                      bus1.id_rt, bus1.id_rs_used, bus1.id_rt_used, bus1.id_imm, bus1.id_off,
                      bus1.id_cond, bus1.id_mem_we, bus1.id_mem_re, bus1.id_reg_we,
                      bus1.halted, bus1.stall_cnt};

  // Opcode tables: which ops read each source, which write a register, and which nibble feeds rs/rt.
  localparam logic [15:0] RS_USE = 16'h2EFF;
  localparam logic [15:0] RT_USE = 16'h03FF;
  localparam logic [15:0] WB_OPS = 16'h4DFF;
  localparam int RS_SLOT [16] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, -1, 1, -1, -1};
  localparam int RT_SLOT [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, -1, -1, -1, -1, -1, -1};

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       rs_used;
    logic       rt_used;
    logic [7:0] imm;
    logic [8:0] off;
    logic [2:0] cond;
    logic       mem_we;
    logic       mem_re;
    logic       reg_we;
  } mdec_t;

  function automatic logic [3:0] nib(input logic [15:0] w, input int k);
    logic [15:0] s;
    s = w >> (4 * k);
    return s[3:0];
  endfunction

  function automatic mdec_t mdec(input logic [15:0] w);
    mdec_t m;
    int    op;
    m       = '0;
    op      = int'(w[15:12]);
    m.op    = w[15:12];
    m.rd    = nib(w, 2);
    m.imm   = w[7:0];
    m.cond  = w[11:9];
    m.off   = (op == 12) ? w[8:0] : 9'h0;
    m.rs_used = RS_USE[op];
    m.rt_used = RT_USE[op];
    if (RS_SLOT[op] >= 0) m.rs = nib(w, RS_SLOT[op]);
    if (RT_SLOT[op] >= 0) m.rt = nib(w, RT_SLOT[op]);
    m.mem_we = (op == 9);
    m.mem_re = (op == 8);
    m.reg_we = WB_OPS[op] && (m.rd != 4'h0);
    return m;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  // Behavioural model state per instance (index 0: stall enabled, 1: stall disabled).
  logic        m_valid    [2];
  logic [15:0] m_instr    [2];
  logic        m_halted   [2];
  logic [15:0] m_cnt      [2];
  logic        m_ready_en [2];

  always @(negedge clk) begin : cmp
    mdec_t d, h;
    logic  hz, adv, er, acc;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk("reset_outs", i, 64'(dut_o[i]), 64'h0);
        m_valid[i]    = 1'b0;
        m_instr[i]    = 16'h0;
        m_halted[i]   = 1'b0;
        m_cnt[i]      = 16'h0;
        m_ready_en[i] = 1'b0;
      end else begin
        d   = mdec(drv_instr);
        h   = mdec(m_instr[i]);
        hz  = (i == 0) && m_valid[i] && h.mem_re && h.reg_we && drv_valid &&
              ((d.rs_used && d.rs == h.rd) || (d.rt_used && d.rt == h.rd));
        adv = !m_valid[i] || drv_er;
        er  = m_ready_en[i] && adv && !hz && !m_halted[i] && !drv_fl;
        chk("id_ready", i, 64'(dut_o[i].id_ready), 64'(er));
        chk("id_valid", i, 64'(dut_o[i].id_valid), 64'(m_valid[i]));
        chk("halted", i, 64'(dut_o[i].halted), 64'(m_halted[i]));
        chk("stall_cnt", i, 64'(dut_o[i].cnt), 64'(m_cnt[i]));
        if (m_valid[i]) begin
          chk("opcode", i, 64'(dut_o[i].op), 64'(h.op));
          chk("rd", i, 64'(dut_o[i].rd), 64'(h.rd));
          chk("rs_used", i, 64'(dut_o[i].rs_used), 64'(h.rs_used));
          chk("rt_used", i, 64'(dut_o[i].rt_used), 64'(h.rt_used));
          if (h.rs_used || h.op == 4'h8) chk("rs", i, 64'(dut_o[i].rs), 64'(h.rs));
          if (h.rt_used) chk("rt", i, 64'(dut_o[i].rt), 64'(h.rt));
          chk("imm", i, 64'(dut_o[i].imm), 64'(h.imm));
          chk("off", i, 64'(dut_o[i].off), 64'(h.off));
          chk("cond", i, 64'(dut_o[i].cond), 64'(h.cond));
          chk("mem_we", i, 64'(dut_o[i].mem_we), 64'(h.mem_we));
          chk("mem_re", i, 64'(dut_o[i].mem_re), 64'(h.mem_re));
          chk("reg_we", i, 64'(dut_o[i].reg_we), 64'(h.reg_we));
        end
        acc = drv_valid && er;
        if (hz && adv && m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'h1;
        if (acc && d.op == 4'hF) m_halted[i] = 1'b1;
        if (drv_fl) m_valid[i] = 1'b0;
        else if (acc) begin
          m_valid[i] = 1'b1;
          m_instr[i] = drv_instr;
        end else if (adv) m_valid[i] = 1'b0;
        m_ready_en[i] = 1'b1;
      end
    end
  end

  task automatic tick(input logic v, input logic [15:0] ins, input logic er, input logic fl);
    @(posedge clk);
    #2;
    drv_valid = v;
    drv_instr = ins;
    drv_er    = er;
    drv_fl    = fl;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    drv_valid = 1'b0;
    drv_instr = 16'h0;
    drv_er    = 1'b0;
    drv_fl    = 1'b0;
    repeat (n) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0]  op;
    logic [11:0] lo;
    op = 4'($urandom_range(0, 14));
    if ($urandom_range(0, 3) == 0) op = 4'h8;
    if ($urandom_range(0, 149) == 0) op = 4'hF;
    if ($urandom_range(0, 3) == 0) lo = 12'($urandom);
    else lo = {2'b00, 2'($urandom), 2'b00, 2'($urandom), 2'b00, 2'($urandom)};
    return {op, lo};
  endfunction

  initial begin
    int halt_cyc;
    do_reset(3);
    tick(1'b0, 16'h0, 1'b1, 1'b0);

    // ADD then SUB back to back
    tick(1'b1, 16'h0123, 1'b1, 1'b0);
    #1 chk("lit_ready_after_reset", 0, 64'(dut_o[0].id_ready), 64'h1);
    tick(1'b1, 16'h1456, 1'b1, 1'b0);
    #1 chk("lit_add_valid", 0, 64'(dut_o[0].id_valid), 64'h1);
    chk("lit_add_rd", 0, 64'(dut_o[0].rd), 64'h1);
    chk("lit_add_rs", 0, 64'(dut_o[0].rs), 64'h2);
    chk("lit_add_rt", 0, 64'(dut_o[0].rt), 64'h3);
    chk("lit_add_reg_we", 0, 64'(dut_o[0].reg_we), 64'h1);
    tick(1'b0, 16'h0, 1'b1, 1'b0);
    #1 chk("lit_sub_valid", 0, 64'(dut_o[0].id_valid), 64'h1);
    chk("lit_sub_op", 0, 64'(dut_o[0].op), 64'h1);
    chk("lit_sub_rd", 0, 64'(dut_o[0].rd), 64'h4);

    // LW r5 then ADD reading r5
    tick(1'b1, 16'h8510, 1'b1, 1'b0);
    tick(1'b1, 16'h0253, 1'b1, 1'b0);
    #1 chk("lit_lu_ready", 0, 64'(dut_o[0].id_ready), 64'h0);
    chk("lit_lu_ready_nostall", 1, 64'(dut_o[1].id_ready), 64'h1);
    tick(1'b1, 16'h0253, 1'b1, 1'b0);
    #1 chk("lit_lu_bubble", 0, 64'(dut_o[0].id_valid), 64'h0);
    chk("lit_lu_cnt", 0, 64'(dut_o[0].cnt), 64'h1);
    chk("lit_nostall_valid", 1, 64'(dut_o[1].id_valid), 64'h1);
    chk("lit_nostall_op", 1, 64'(dut_o[1].op), 64'h0);
    chk("lit_nostall_cnt", 1, 64'(dut_o[1].cnt), 64'h0);
    tick(1'b0, 16'h0, 1'b1, 1'b0);
    #1 chk("lit_lu_consumer_valid", 0, 64'(dut_o[0].id_valid), 64'h1);
    chk("lit_lu_consumer_rd", 0, 64'(dut_o[0].rd), 64'h2);
    chk("lit_lu_consumer_rs", 0, 64'(dut_o[0].rs), 64'h5);

    // SW held while EX is not ready
    tick(1'b1, 16'h9340, 1'b1, 1'b0);
    repeat (3) begin
      tick(1'b1, 16'h0111, 1'b0, 1'b0);
      #1 chk("lit_sw_valid", 0, 64'(dut_o[0].id_valid), 64'h1);
      chk("lit_sw_op", 0, 64'(dut_o[0].op), 64'h9);
      chk("lit_sw_ready", 0, 64'(dut_o[0].id_ready), 64'h0);
      chk("lit_sw_mem_we", 0, 64'(dut_o[0].mem_we), 64'h1);
      chk("lit_sw_reg_we", 0, 64'(dut_o[0].reg_we), 64'h0);
    end
    tick(1'b0, 16'h0, 1'b1, 1'b0);

    // ADD to r0, then PCS
    tick(1'b1, 16'h0012, 1'b1, 1'b0);
    tick(1'b1, 16'hE700, 1'b1, 1'b0);
    #1 chk("lit_r0_valid", 0, 64'(dut_o[0].id_valid), 64'h1);
    chk("lit_r0_reg_we", 0, 64'(dut_o[0].reg_we), 64'h0);
    tick(1'b0, 16'h0, 1'b1, 1'b0);
    #1 chk("lit_pcs_op", 0, 64'(dut_o[0].op), 64'hE);
    chk("lit_pcs_reg_we", 0, 64'(dut_o[0].reg_we), 64'h1);
    chk("lit_pcs_rs_used", 0, 64'(dut_o[0].rs_used), 64'h0);
    chk("lit_pcs_rt_used", 0, 64'(dut_o[0].rt_used), 64'h0);

    // B then flush with a word waiting
    tick(1'b1, 16'hC3FF, 1'b1, 1'b0);
    tick(1'b1, 16'h0123, 1'b0, 1'b1);
    #1 chk("lit_b_op", 0, 64'(dut_o[0].op), 64'hC);
    chk("lit_b_off", 0, 64'(dut_o[0].off), 64'h1FF);
    chk("lit_b_cond", 0, 64'(dut_o[0].cond), 64'h1);
    chk("lit_flush_ready", 0, 64'(dut_o[0].id_ready), 64'h0);
    tick(1'b1, 16'h0123, 1'b1, 1'b0);
    #1 chk("lit_flush_valid", 0, 64'(dut_o[0].id_valid), 64'h0);
    chk("lit_after_flush_ready", 0, 64'(dut_o[0].id_ready), 64'h1);
    tick(1'b0, 16'h0, 1'b1, 1'b0);
    #1 chk("lit_after_flush_op", 0, 64'(dut_o[0].op), 64'h0);
    chk("lit_after_flush_valid", 0, 64'(dut_o[0].id_valid), 64'h1);

    // Randomized traffic with occasional halts and resets
    halt_cyc = 0;
    for (int c = 0; c < 4000; c++) begin
      if (dut_o[0].halted) halt_cyc++;
      if (halt_cyc > 15 || $urandom_range(0, 499) == 0) begin
        do_reset($urandom_range(1, 3));
        halt_cyc = 0;
      end else begin
        tick($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 7,
             $urandom_range(0, 11) == 0);
      end
    end

    // HLT, flush while halted, then reset mid-stream
    do_reset(2);
    tick(1'b0, 16'h0, 1'b1, 1'b0);
    tick(1'b1, 16'h8510, 1'b1, 1'b0);
    tick(1'b1, 16'h0253, 1'b1, 1'b0);
    tick(1'b1, 16'h0253, 1'b1, 1'b0);
    tick(1'b1, 16'hF000, 1'b1, 1'b0);
    tick(1'b1, 16'h0123, 1'b0, 1'b0);
    #1 chk("lit_hlt_halted", 0, 64'(dut_o[0].halted), 64'h1);
    chk("lit_hlt_op", 0, 64'(dut_o[0].op), 64'hF);
    chk("lit_hlt_valid", 0, 64'(dut_o[0].id_valid), 64'h1);
    chk("lit_hlt_ready", 0, 64'(dut_o[0].id_ready), 64'h0);
    tick(1'b1, 16'h0123, 1'b0, 1'b1);
    tick(1'b1, 16'h0123, 1'b1, 1'b0);
    #1 chk("lit_halt_flush_valid", 0, 64'(dut_o[0].id_valid), 64'h0);
    chk("lit_halt_sticky", 0, 64'(dut_o[0].halted), 64'h1);
    chk("lit_halt_ready", 0, 64'(dut_o[0].id_ready), 64'h0);
    chk("lit_halt_cnt", 0, 64'(dut_o[0].cnt), 64'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("lit_async_reset_outs", 0, 64'(dut_o[0]), 64'h0);
    chk("lit_async_reset_outs", 1, 64'(dut_o[1]), 64'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick(1'b0, 16'h0, 1'b1, 1'b0);
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
